// File: rtl/universal_register_unit.sv
// Word register with opcode-selected update: hold, load, shift, rotate, inc/dec.
// Carry captures shift-out, wrap or saturation; zero decodes the stored word.
module universal_register_unit #(
    parameter int                   WORD_SIZE   = 8,
    parameter logic [WORD_SIZE-1:0] RESET_VALUE = '0,
    parameter bit                   SATURATE    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [2:0]           op,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 ser_in,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 carry,
    output logic                 zero
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_INC  = 3'b110,
        OP_DEC  = 3'b111
    } op_e;

    localparam logic [WORD_SIZE-1:0] ONES = '1;
    localparam logic [WORD_SIZE-1:0] ONE  = WORD_SIZE'(1);

    logic [WORD_SIZE-1:0] q_q, q_d;
    logic                 c_q, c_d;
    logic [WORD_SIZE:0]   inc_sum;
    logic                 q_ones, q_zero;

    assign inc_sum = {1'b0, q_q} + {1'b0, ONE};
    assign q_ones  = (q_q == ONES);
    assign q_zero  = (q_q == '0);

    // Only the op decode lives here; rst/clr/en priority is applied in the flop block.
    always_comb begin
        q_d = q_q;
        c_d = c_q;
        case (op_e'(op))
            OP_HOLD: ;
            OP_LOAD: begin q_d = data_in; c_d = 1'b0; end
            OP_SHL:  begin q_d = {q_q[WORD_SIZE-2:0], ser_in};  c_d = q_q[WORD_SIZE-1]; end
            OP_SHR:  begin q_d = {ser_in, q_q[WORD_SIZE-1:1]};  c_d = q_q[0]; end
            OP_ROL:  begin q_d = {q_q[WORD_SIZE-2:0], q_q[WORD_SIZE-1]}; c_d = q_q[WORD_SIZE-1]; end
            OP_ROR:  begin q_d = {q_q[0], q_q[WORD_SIZE-1:1]};  c_d = q_q[0]; end
            OP_INC: begin
                if (SATURATE) begin
                    q_d = q_ones ? q_q : inc_sum[WORD_SIZE-1:0];
                    c_d = q_ones;
                end else begin
                    q_d = inc_sum[WORD_SIZE-1:0];
                    c_d = inc_sum[WORD_SIZE];
                end
            end
            OP_DEC: begin
                // Borrow and saturation both flag on q==0; only the held value differs.
                q_d = (SATURATE && q_zero) ? q_q : q_q - ONE;
                c_d = q_zero;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            q_q <= RESET_VALUE;
            c_q <= 1'b0;
        end else if (en) begin
            q_q <= q_d;
            c_q <= c_d;
        end
    end

    assign data_out = q_q;
    assign carry    = c_q;
    assign zero     = q_zero;

endmodule

// File: tb/tb_universal_register_unit.sv
// Scoreboard bench: wrap and saturating instances driven in parallel and
// checked against an arithmetic reference model.
module tb_universal_register_unit;

    logic       clk = 1'b0;
    logic       rst, en, clr, ser_in;
    logic [2:0] op;
    logic [7:0] data_in;
    logic [7:0] dout0, dout1;
    logic       c0, c1, z0, z1;

    always #5 clk = ~clk;

    universal_register_unit #(.WORD_SIZE(8), .RESET_VALUE(8'h00), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .op(op), .data_in(data_in),
        .ser_in(ser_in), .data_out(dout0), .carry(c0), .zero(z0));

    universal_register_unit #(.WORD_SIZE(8), .RESET_VALUE(8'h00), .SATURATE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .op(op), .data_in(data_in),
        .ser_in(ser_in), .data_out(dout1), .carry(c1), .zero(z1));

    typedef struct {
        int    q[2];
        int    c[2];
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   mq[2], mc[2];
    bit   mvalid = 1'b0;
    int   checks = 0, failures = 0;

    function automatic void model(input int sat, input int q, input int c,
                                  input int r, input int cl, input int e, input int o,
                                  input int d, input int s, output int nq, output int nc);
        nq = q; nc = c;
        if (r == 0 || cl == 1) begin nq = 0; nc = 0; end
        else if (e == 1) begin
            case (o)
                0: ;
                1: begin nq = d; nc = 0; end
                2: begin nq = (q * 2) % 256 + s;        nc = q / 128; end
                3: begin nq = q / 2 + s * 128;          nc = q % 2; end
                4: begin nq = (q * 2) % 256 + q / 128;  nc = q / 128; end
                5: begin nq = q / 2 + (q % 2) * 128;    nc = q % 2; end
                6: if (sat != 0) begin nq = (q == 255) ? 255 : q + 1; nc = (q == 255); end
                   else begin nq = (q + 1) % 256; nc = (q == 255); end
                default: if (sat != 0) begin nq = (q == 0) ? 0 : q - 1; nc = (q == 0); end
                   else begin nq = (q + 255) % 256; nc = (q == 0); end
            endcase
        end
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock: drive after negedge, fold into the model at the posedge.
    task automatic step(input bit r, input bit cl, input bit e, input int o,
                        input int d, input bit s, input string tag);
        exp_t x;
        int nq, nc;
        @(negedge clk); #1;
        rst = r; clr = cl; en = e; op = 3'(o); data_in = 8'(d); ser_in = s;
        if (!e && r && !cl) op = 3'bxxx;
        @(posedge clk);
        if (r == 1'b0) mvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            model(i, mq[i], mc[i], r, cl, e, o, d, s, nq, nc);
            mq[i] = nq; mc[i] = nc;
        end
        if (mvalid) begin
            x.q = mq; x.c = mc; x.tag = tag;
            exp_q.push_back(x);
        end
    endtask

    // Monitor: registered outputs are present every cycle, checked on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            check({x.tag, ".q0"}, int'(dout0), x.q[0]);
            check({x.tag, ".c0"}, int'(c0),    x.c[0]);
            check({x.tag, ".z0"}, int'(z0),    int'(x.q[0] == 0));
            check({x.tag, ".q1"}, int'(dout1), x.q[1]);
            check({x.tag, ".c1"}, int'(c1),    x.c[1]);
            check({x.tag, ".z1"}, int'(z1),    int'(x.q[1] == 0));
        end
    end

    initial begin
        int budget;
        mq = '{0, 0}; mc = '{0, 0};
        rst = 1'b1; clr = 1'b0; en = 1'b0; op = 3'd0; data_in = 8'h00; ser_in = 1'b0;

        step(0, 0, 1, 1, 'hA5, 0, "rst1");
        step(0, 0, 1, 1, 'hA5, 0, "rst2");
        step(1, 0, 1, 1, 'hA5, 0, "load_a5");
        #2 rst = 1'b0;
        #2 check("rst_async", int'(dout0), 'hA5);
        step(0, 0, 1, 1, 'h11, 0, "rst_edge");

        step(1, 0, 1, 1, 'h81, 0, "ld81");
        step(1, 0, 1, 2, 0, 0, "shl");
        step(1, 0, 1, 3, 0, 1, "shr1");
        step(1, 0, 1, 3, 0, 0, "shr0");

        step(1, 0, 1, 1, 'h01, 0, "ld01");
        step(1, 0, 1, 5, 0, 0, "ror");
        step(1, 0, 1, 4, 0, 0, "rol1");
        step(1, 0, 1, 4, 0, 0, "rol2");

        step(1, 0, 1, 1, 'hFF, 0, "ldff");
        step(1, 0, 1, 6, 0, 0, "inc_wrap");
        step(1, 0, 1, 7, 0, 0, "dec_a");
        step(1, 0, 1, 7, 0, 0, "dec_b");

        step(1, 0, 1, 1, 'hFE, 0, "ldfe");
        repeat (3) step(1, 0, 1, 6, 0, 0, "inc_sat");
        step(1, 0, 1, 1, 'h01, 0, "ld01b");
        repeat (2) step(1, 0, 1, 7, 0, 0, "dec_sat");

        step(1, 0, 1, 1, 'h10, 0, "ld10");
        step(1, 1, 1, 1, 'h33, 0, "clr_load");
        repeat (3) step(1, 0, 0, 6, 0, 0, "en0_hold");
        step(1, 0, 1, 1, 'h05, 0, "ld05");
        step(1, 0, 1, 6, 0, 0, "cnt1");
        step(1, 0, 1, 6, 0, 0, "cnt2");
        step(0, 0, 1, 6, 0, 0, "cnt_rst");
        step(1, 0, 1, 6, 0, 0, "cnt_resume");

        for (int n = 0; n < 600; n++) begin
            int r, cl, e;
            r  = ($urandom_range(0, 40) != 0);
            cl = ($urandom_range(0, 30) == 0);
            e  = ($urandom_range(0, 5) != 0);
            step(r[0], cl[0], e[0], $urandom_range(0, 7), $urandom_range(0, 255),
                 $urandom_range(0, 1), "rand");
        end

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/universal_register_unit.md
Name: universal_register_unit

Overview:
- Parametrised next-generation register for the datapath: one word-wide storage register with an opcode-selected update (hold, load, logical shift, rotate, increment, decrement).
- Adds carry/borrow capture, a zero flag, a synchronous clear and optional saturating arithmetic.
- Sits wherever a plain load-enable register is used today (accumulator, shift/count register, address pointer). Used with op=LOAD it behaves as a load-enable register.

Parameters:
- WORD_SIZE, 8, width of data_in/data_out (legal 2..64).
- RESET_VALUE, 0, value loaded into data_out by reset and by clr (WORD_SIZE bits).
- SATURATE, 0, 0 = INC/DEC wrap modulo 2^WORD_SIZE; 1 = INC/DEC clamp at all-ones/zero.

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk only.
- rst  input  1  reset, synchronous, active-low.
- en  input  1  update enable; 0 = hold all state.
- clr  input  1  synchronous clear to RESET_VALUE (active-high).
- op  input  3  operation select, encoding below.
- data_in  input  WORD_SIZE  parallel load value.
- ser_in  input  1  serial fill bit for SHL/SHR.
- data_out  output  WORD_SIZE  registered value (q).
- carry  output  1  registered carry/borrow/shift-out flag.
- zero  output  1  combinational, 1 when data_out == 0.

Behaviour:
- Reset:
  - rst sampled only at posedge clk. rst=0 at an edge gives data_out=RESET_VALUE and carry=0.
  - zero follows data_out. With default RESET_VALUE, zero=1 after reset.
  - No asynchronous path. rst falling between edges has no effect until the next edge.
- Priority per edge: rst=0 > clr=1 > en=0 > op.
- clr=1 (rst=1): data_out=RESET_VALUE, carry=0. en and op are ignored.
- en=0 (rst=1, clr=0): data_out and carry hold.
- op encoding (en=1), with q = current data_out, W = WORD_SIZE:
  - 000 HOLD: q and carry unchanged.
  - 001 LOAD: q<=data_in; carry<=0.
  - 010 SHL: q<={q[W-2:0],ser_in}; carry<=q[W-1].
  - 011 SHR: q<={ser_in,q[W-1:1]}; carry<=q[0].
  - 100 ROL: q<={q[W-2:0],q[W-1]}; carry<=q[W-1].
  - 101 ROR: q<={q[0],q[W-1:1]}; carry<=q[0].
  - 110 INC, SATURATE=0: {carry,q}<=q+1 in W+1 bits. Carry=1 only on wrap from all-ones to 0.
  - 110 INC, SATURATE=1: if q is all-ones, q holds and carry<=1; otherwise q<=q+1 and carry<=0.
  - 111 DEC, SATURATE=0: q<=q-1. carry<=1 only when q was 0 (borrow; wraps to all-ones).
  - 111 DEC, SATURATE=1: if q==0, q holds and carry<=1; otherwise q<=q-1 and carry<=0.
- Latency:
  - One cycle from inputs to data_out/carry.
  - zero is valid in the same cycle as data_out (combinational decode of the register, no extra delay).
- Arithmetic is unsigned, exactly W bits; no sign handling.
- Simultaneous events are fully resolved by the priority above. Example: clr=1 with op=LOAD gives RESET_VALUE, not data_in.
- Reset mid-sequence (e.g. during a count): the next edge with rst=0 overrides everything. The first edge with rst=1 resumes normal operation from RESET_VALUE.
- Inputs are don't-care while rst=0 or clr=1. X on op with en=0 must not corrupt state.

Test Plan:
- Reset: rst=0 for 2 edges with en=1, op=LOAD, data_in=8'hA5 → data_out=8'h00, carry=0, zero=1. Release rst → next edge LOAD gives 8'hA5, zero=0. Dropping rst between edges changes nothing until the edge.
- Shift: LOAD 8'h81; SHL with ser_in=0 → 8'h02, carry=1; SHR with ser_in=1 → 8'h81, carry=0; SHR with ser_in=0 → 8'h40, carry=1.
- Rotate: LOAD 8'h01; ROR → 8'h80, carry=1; ROL → 8'h01, carry=1; ROL → 8'h02, carry=0.
- Wrap arithmetic (SATURATE=0): LOAD 8'hFF; INC → 8'h00, carry=1, zero=1; DEC → 8'hFF, carry=1; DEC → 8'hFE, carry=0.
- Saturating arithmetic (SATURATE=1): LOAD 8'hFE; INC ×3 → 8'hFF (carry=0), 8'hFF (carry=1), 8'hFF (carry=1). LOAD 8'h01; DEC ×2 → 8'h00 (carry=0, zero=1), 8'h00 (carry=1).
- Priority:
  - From 8'h10, clr=1 with op=LOAD, data_in=8'h33 → 8'h00, carry=0.
  - en=0 with op=INC for 3 edges → holds 8'h00.
  - Counting INC from 8'h05 with rst=0 on the 3rd edge → 8'h06, 8'h07, then 8'h00.
